pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Next-generation inter-stage pipeline register for the 5-stage MIPS core. Replaces the fixed-payload, write-enable-only stage registers.
- Carries instr, pc and a parametrised number of data lanes.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so in_ready is a pure register output.
- Supports synchronous flush that inserts a nop bubble. Instantiated between every pair of stages (F/D, D/E, E/M, M/W).

Parameters:
LANES, 2, number of data payload words (1..8)
WIDTH, 32, bits per data lane
PC_RESET, 32'h0000_3000, pc_out value after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all held entries
in_valid  in  1  upstream presents a payload
in_ready  out  1  stage can accept; registered
instr_in  in  32  instruction word
pc_in  in  32  instruction address
data_in  in  LANES*WIDTH  data lanes, lane k at bits [k*WIDTH +: WIDTH]
out_valid  out  1  main entry holds a valid payload
out_ready  in  1  downstream consumes this cycle
instr_out  out  32  main-entry instruction; 0 (nop) when out_valid=0
pc_out  out  32  main-entry pc
data_out  out  LANES*WIDTH  main-entry data; 0 when out_valid=0
stall_cnt  out  32  stall-cycle counter (only with the optional feature)

Behaviour:
- State: main entry (drives outputs) plus skid entry, each with a valid bit. All updates occur on posedge clk, except reset.
- Reset (async, asserted on the reset edge, no clock needed):
  - main_valid=0, skid_valid=0, in_ready=1.
  - instr_out=0, pc_out=PC_RESET, data_out=0.
  - skid payload=0.
- Handshakes: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = !skid_valid (registered).
- Transitions (flush=0), written as (main_valid, skid_valid):
  - EMPTY (0,0): accept -> main loads input -> ONE.
  - ONE (1,0):
    - accept & drain -> main loads input, stays ONE.
    - drain only -> main cleared -> EMPTY.
    - accept only -> skid loads input -> FULL; in_ready=0 next cycle.
  - FULL (1,1), no accept possible:
    - drain -> skid moves into main, skid cleared -> ONE; in_ready=1 next cycle.
    - otherwise hold.
- Ordering: payload order is strictly FIFO; no entry is ever dropped or duplicated without flush.
- Latency:
  - Input accepted at edge N appears on outputs after edge N when the stage was EMPTY or draining.
  - Sustained throughput is 1 per cycle with out_ready held high.
- Clearing main: whenever main becomes invalid, instr_out and data_out are written 0; pc_out holds its last value.
- Flush:
  - Highest priority below reset: both valid bits -> 0, skid payload -> 0, instr_out/data_out -> 0, pc_out held, in_ready -> 1.
  - A same-cycle accept is consumed and discarded.
  - A same-cycle drain counts as completed downstream.
- Simultaneous flush and reset: reset wins.
- Reset mid-transfer: all entries lost, outputs at reset values immediately.
- out_ready when out_valid=0: ignored.

Optional Feature:
- PIPE_STAGE_STALL_CNT_EN defined:
  - stall_cnt is a 32-bit counter, reset to 0 by reset.
  - Increments by 1 each cycle with out_valid=1 & out_ready=0.
  - Wraps from 32'hFFFF_FFFF to 0; flush does not clear it.
- Not defined: stall_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Reset with clk stopped: assert reset -> out_valid=0, in_ready=1, pc_out=32'h0000_3000, instr_out=0 without any clock edge.
- Streaming:
  - Stimulus: out_ready=1, 4 back-to-back inputs, instr 32'h2408_0001..0004, pc 0x3000..0x300C.
  - Required response: outputs appear one cycle after each accept, in order, with no bubbles; in_ready stays 1.
- Backpressure fill:
  - Stimulus: out_ready=0, send A (pc 0x3000) then B (pc 0x3004).
  - Required response: in_ready=0 after B; out holds A. Raise out_ready for 2 cycles -> A then B emerge; in_ready=1 one cycle after the first drain.
- Flush while FULL: flush=1 with in_valid=1 (C, pc 0x3008) -> next cycle out_valid=0, instr_out=0, data_out=0, pc_out unchanged, in_ready=1; C never appears.
- Lane packing:
  - Stimulus: LANES=3, WIDTH=16, data_in=48'h3333_2222_1111.
  - Required response: data_out lane0=16'h1111, lane2=16'h3333 after transfer.
- PIPE_STAGE_STALL_CNT_EN defined:
  - Stimulus: hold out_valid=1, out_ready=0 for 5 cycles, then 1 cycle drain, then flush.
  - Required response: stall_cnt=5, unchanged by drain and flush.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and 2-entry skid buffer.
// Optional PIPE_STAGE_STALL_CNT_EN adds a 32-bit downstream-stall counter on stall_cnt.

module pipe_stage_skid_lane #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         main_ld_in,
    input  logic         main_ld_skid,
    input  logic         main_clr,
    input  logic         skid_ld,
    input  logic         skid_clr,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out
);
    logic [W-1:0] skid_q;

    // Clears take priority so flush and drain-to-empty always leave zeros behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out  <= '0;
            skid_q <= '0;
        end else begin
            if (main_clr)          d_out <= '0;
            else if (main_ld_skid) d_out <= skid_q;
            else if (main_ld_in)   d_out <= d_in;

            if (skid_clr)          skid_q <= '0;
            else if (skid_ld)      skid_q <= d_in;
        end
    end
endmodule

module pipe_stage_skid #(
    parameter int          LANES    = 2,
    parameter int          WIDTH    = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instr_in,
    input  logic [31:0]            pc_in,
    input  logic [LANES*WIDTH-1:0] data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            instr_out,
    output logic [31:0]            pc_out,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [31:0]            stall_cnt
);
    logic main_valid, skid_valid;
    logic accept, drain;
    logic main_ld_in, main_ld_skid, main_clr, skid_ld, skid_clr;
    logic [31:0] skid_pc;

    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid & out_ready;

    // in_ready mirrors !skid_valid, so accept can never coincide with a full skid.
    assign main_ld_in   = !flush & accept & (!main_valid | drain);
    assign main_ld_skid = !flush & skid_valid & drain;
    assign main_clr     = flush | (drain & !accept & !skid_valid);
    assign skid_ld      = !flush & accept & main_valid & !drain;
    assign skid_clr     = flush | main_ld_skid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            pc_out     <= PC_RESET;
            skid_pc    <= '0;
        end else begin
            if (main_clr)                       main_valid <= 1'b0;
            else if (main_ld_in | main_ld_skid) main_valid <= 1'b1;

            if (skid_clr)     skid_valid <= 1'b0;
            else if (skid_ld) skid_valid <= 1'b1;

            if (skid_clr)     in_ready <= 1'b1;
            else if (skid_ld) in_ready <= 1'b0;

            // pc is never cleared; it keeps the last main-entry address.
            if (main_ld_skid)    pc_out <= skid_pc;
            else if (main_ld_in) pc_out <= pc_in;

            if (skid_clr)     skid_pc <= '0;
            else if (skid_ld) skid_pc <= pc_in;
        end
    end

    pipe_stage_skid_lane #(.W(32)) u_instr (
        .clk(clk), .reset(reset),
        .main_ld_in(main_ld_in), .main_ld_skid(main_ld_skid), .main_clr(main_clr),
        .skid_ld(skid_ld), .skid_clr(skid_clr),
        .d_in(instr_in), .d_out(instr_out)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pipe_stage_skid_lane #(.W(WIDTH)) u_lane (
            .clk(clk), .reset(reset),
            .main_ld_in(main_ld_in), .main_ld_skid(main_ld_skid), .main_clr(main_clr),
            .skid_ld(skid_ld), .skid_clr(skid_clr),
            .d_in(data_in[k*WIDTH +: WIDTH]), .d_out(data_out[k*WIDTH +: WIDTH])
        );
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       stall_cnt <= '0;
        else if (main_valid & !out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized bench for pipe_stage_skid: FIFO-queue reference model plus directed literal checks.
module tb_pipe_stage_skid;
    localparam int          LANES = 3;
    localparam int          WIDTH = 16;
    localparam int          DW    = LANES * WIDTH;
    localparam logic [31:0] PCR   = 32'h0000_3000;

    logic clk = 0, clk_run = 0;
    logic reset = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] instr_in = 0, pc_in = 0;
    logic [DW-1:0] data_in = 0;
    logic in_ready, out_valid;
    logic [31:0] instr_out, pc_out, stall_cnt;
    logic [DW-1:0] data_out;

    int errors = 0, checks = 0;
    bit chk_en = 0;

    typedef struct packed {
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    logic [31:0] m_pc = PCR;
    logic [31:0] m_stall = 0;

    pipe_stage_skid #(.LANES(LANES), .WIDTH(WIDTH), .PC_RESET(PCR)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_out(instr_out), .pc_out(pc_out), .data_out(data_out),
        .stall_cnt(stall_cnt)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference: the stage is a FIFO of capacity 2 whose head is the visible output.
    always @(posedge clk or posedge reset) begin
        bit acc, drn;
        if (reset) begin
            q.delete();
            m_pc    = PCR;
            m_stall = 0;
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (q.size() > 0 && !out_ready) m_stall++;
            if (flush) q.delete();
            else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(ent_t'{instr_in, pc_in, data_in});
            end
            if (q.size() > 0) m_pc = q[0].pc;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
            chk("instr_out", 64'(instr_out), (q.size() > 0) ? 64'(q[0].instr) : 64'd0);
            chk("data_out",  64'(data_out),  (q.size() > 0) ? 64'(q[0].data)  : 64'd0);
            chk("pc_out",    64'(pc_out),    64'(m_pc));
`ifdef PIPE_STAGE_STALL_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`else
            chk("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        end
    end

    initial begin
        logic [31:0] exp_stall;
`ifdef PIPE_STAGE_STALL_CNT_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        // Async reset with no clock running
        #3 reset = 1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_pc_out",    64'(pc_out),    64'h3000);
        chk("rst_instr_out", 64'(instr_out), 64'd0);
        chk("rst_data_out",  64'(data_out),  64'd0);
        clk_run = 1;
        @(posedge clk);
        #2 reset = 0;
        chk_en = 1;

        // Streaming with lane packing on the first beat
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            instr_in = 32'h2408_0001 + i;
            pc_in    = 32'h3000 + 4 * i;
            data_in  = (i == 0) ? 48'h3333_2222_1111 : DW'({$urandom, $urandom});
            step();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_instr", 64'(instr_out), 64'(32'h2408_0001 + i));
            chk("stream_pc",    64'(pc_out),    64'(32'h3000 + 4 * i));
            chk("stream_ready", 64'(in_ready),  64'd1);
            if (i == 0) begin
                chk("lane0", 64'(data_out[15:0]),  64'h1111);
                chk("lane1", 64'(data_out[31:16]), 64'h2222);
                chk("lane2", 64'(data_out[47:32]), 64'h3333);
            end
        end
        in_valid = 0;
        step();
        chk("stream_end_valid", 64'(out_valid), 64'd0);
        chk("stream_end_instr", 64'(instr_out), 64'd0);
        chk("stream_end_data",  64'(data_out),  64'd0);
        chk("stream_end_pc",    64'(pc_out),    64'h300C);

        // Backpressure fill then drain
        out_ready = 0;
        in_valid = 1; instr_in = 32'h0000_000A; pc_in = 32'h3000; data_in = 48'hA;
        step();
        chk("bp_a_ready", 64'(in_ready), 64'd1);
        chk("bp_a_instr", 64'(instr_out), 64'hA);
        instr_in = 32'h0000_000B; pc_in = 32'h3004; data_in = 48'hB;
        step();
        in_valid = 0;
        chk("bp_full_ready", 64'(in_ready),  64'd0);
        chk("bp_full_instr", 64'(instr_out), 64'hA);
        chk("bp_full_pc",    64'(pc_out),    64'h3000);
        out_ready = 1;
        step();
        chk("bp_b_instr", 64'(instr_out), 64'hB);
        chk("bp_b_pc",    64'(pc_out),    64'h3004);
        chk("bp_b_ready", 64'(in_ready),  64'd1);
        step();
        chk("bp_empty_valid", 64'(out_valid), 64'd0);
        chk("bp_empty_pc",    64'(pc_out),    64'h3004);

        // Flush while full, with an input presented
        out_ready = 0;
        in_valid = 1; instr_in = 32'h0000_000D; pc_in = 32'h3010; data_in = 48'hD;
        step();
        instr_in = 32'h0000_000E; pc_in = 32'h3014; data_in = 48'hE;
        step();
        instr_in = 32'h0000_000C; pc_in = 32'h3008; data_in = 48'hC;
        flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_instr", 64'(instr_out), 64'd0);
        chk("fl_data",  64'(data_out),  64'd0);
        chk("fl_pc",    64'(pc_out),    64'h3010);
        chk("fl_ready", 64'(in_ready),  64'd1);
        out_ready = 1;
        repeat (3) step();
        chk("fl_no_c", 64'(out_valid), 64'd0);

        // Reset mid-transfer, no clock edge needed
        out_ready = 0; in_valid = 1; instr_in = 32'h77; pc_in = 32'h3100;
        step();
        step();
        in_valid = 0;
        reset = 1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready),  64'd1);
        chk("mid_rst_pc",    64'(pc_out),    64'h3000);
        chk("mid_rst_instr", 64'(instr_out), 64'd0);
        @(posedge clk);
        #2 reset = 0;

        // Stall counter: 5 stalled cycles, then drain, then flush
        out_ready = 0; in_valid = 1; instr_in = 32'h55; pc_in = 32'h3200;
        step();
        in_valid = 0;
        repeat (5) step();
        chk("stall_5", 64'(stall_cnt), 64'(exp_stall));
        out_ready = 1;
        step();
        chk("stall_drain", 64'(stall_cnt), 64'(exp_stall));
        out_ready = 0; flush = 1;
        step();
        flush = 0;
        chk("stall_flush", 64'(stall_cnt), 64'(exp_stall));

        // Randomized traffic, checked every cycle by the model
        repeat (3000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(19) == 0);
            instr_in  = $urandom;
            pc_in     = $urandom;
            data_in   = DW'({$urandom, $urandom});
            if ($urandom_range(299) == 0) begin
                reset = 1;
                #1;
                chk("rnd_rst_valid", 64'(out_valid), 64'd0);
                chk("rnd_rst_pc",    64'(pc_out),    64'h3000);
                @(posedge clk);
                #2 reset = 0;
            end
            step();
        end
        flush = 0; in_valid = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
